gpio_cmd_decoder: RTL and testbench
===================================

Name: gpio_cmd_decoder

Overview:
Front-end command stage between the processor GPIO and the address/control FSM of the 2D convolution datapath.
- Decodes a 32-bit command word into the FSM control levels: load, SoP, valid pulse and image length.
- Presents pixel data for the line memories.
- Captures read-back results and returns a status/ack word to the processor over the GPIO input.

Parameters:
NB_GPIO, 32, GPIO word width
NB_IMAGE, 10, image-length field width (matches FSM i_imgLength)
NB_DATA, 24, pixel payload / result width (3 packed 8-bit pixels)
READ_LATENCY, 2, cycles from o_valid pulse to valid i_result

Ports:
i_CLK  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_gpio_data  in  NB_GPIO  command word from processor
i_EoP  in  1  end-of-process from FSM
i_changeBlock  in  1  block-done from FSM
i_result  in  NB_DATA  read data from result memory
o_gpio_data  out  NB_GPIO  status/ack/result word to processor
o_load  out  1  load level to FSM
o_SoP  out  1  start-of-process level to FSM
o_valid  out  1  one-cycle valid pulse to FSM
o_imgLength  out  NB_IMAGE  image length to FSM
o_data  out  NB_DATA  pixel data to line memories
o_fsm_reset  out  1  one-cycle soft-reset pulse to FSM

Behaviour:
Command word layout:
- [31:29] opcode; [28] strobe; [23:0] payload.
- A command executes in the cycle after i_gpio_data[28] differs from its registered previous value.
- One command per toggle.

Opcodes:
- 0 NOP
- 1 RESET
- 2 SET_LEN (payload[NB_IMAGE-1:0])
- 3 LOAD
- 4 DATA
- 5 START
- 6 READ
- 7 IDLE

States: IDLE, LOAD, RUN, DONE (2-bit, encodings 0..3).
- IDLE: o_load=0, o_SoP=0.
  - SET_LEN latches o_imgLength.
  - LOAD -> LOAD state.
  - START -> RUN.
  - READ with i_EoP=1 -> one o_valid pulse.
- LOAD: o_load=1.
  - DATA latches payload into o_data and pulses o_valid in the same cycle (data stable from that cycle until the next DATA).
  - IDLE opcode -> IDLE.
- RUN: o_SoP=1, held until i_EoP is sampled high, then -> DONE.
- DONE: o_SoP=0 for one cycle, then -> IDLE.

o_valid rules:
- Never high on two consecutive cycles, so every pulse is a distinct rising edge for the FSM.
- A strobe arriving in the cycle right after a pulse is held one cycle, then executed. No command is lost.

Read-back:
- i_result is captured exactly READ_LATENCY cycles after the READ-generated o_valid pulse.
- The ack for READ updates only at capture. A strobe arriving while a READ capture is pending is held until capture completes.

o_gpio_data layout:
- [31:30] state
- [29] i_EoP
- [28] ack = strobe value of last completed command
- [27] sticky illegal-command error
- [26] sticky block-done (set on i_changeBlock; cleared on next LOAD or READ execution)
- [25:24] 0
- [23:0] captured result

Illegal commands (SET_LEN/START outside IDLE, DATA outside LOAD, READ with i_EoP=0, LOAD outside IDLE):
- No effect on state or outputs.
- Set error bit.
- Ack still updates, so the processor never stalls.
- Error bit is cleared only by reset or the RESET opcode.

RESET opcode:
- Pulses o_fsm_reset for 1 cycle.
- Returns to IDLE; clears o_imgLength, o_data, result, error and block-done. Ack updates.

Reset (i_reset):
- All outputs 0, state IDLE.
- Previous-strobe register loads the current i_gpio_data[28], so no spurious command executes after reset.
- Any pending READ capture is cancelled.
- Mid-operation reset takes priority over all events.

Simultaneous events: i_EoP high in the same cycle as a strobe in RUN is handled as the RUN->DONE transition; the strobe is held one cycle.

Decomposition:
Shared package (cmd_pkg):
- opcode constants OP_NOP..OP_IDLE
- state encodings ST_IDLE/ST_LOAD/ST_RUN/ST_DONE
- status bit-position constants
- strobe/opcode field positions

Sub-module: strobe_edge_det (strobe register plus toggle detect plus hold-one-cycle logic). The remainder stays in the top.

Test Plan:
1. Reset with i_gpio_data[28]=1, then hold -> no o_valid, state 0, o_gpio_data=0 apart from ack/EoP bits.
2. SET_LEN 0x3FF, LOAD, then 4 DATA strobes with payloads 0x010203..0x0A0B0C -> o_imgLength=1023, o_load=1, exactly 4 single-cycle o_valid pulses with matching o_data, ack tracks strobe.
3. Back-to-back DATA strobes on consecutive cycles -> two o_valid pulses separated by exactly 1 low cycle.
4. START with i_EoP driven high 20 cycles later -> o_SoP high 20 cycles, state RUN->DONE->IDLE, o_SoP low by cycle 22.
5. READ with i_EoP=1, i_result=0xABCDEF -> o_valid pulse, o_gpio_data[23:0]=0xABCDEF and ack updated exactly READ_LATENCY=2 cycles later.
6. DATA issued in IDLE -> no o_valid, bit 27 set, ack updated; RESET opcode -> o_fsm_reset 1-cycle pulse, bit 27 cleared.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared definitions for the GPIO command decoder: opcodes, FSM state
// encodings and the bit positions of the command and status words.
package cmd_pkg;

    // Command opcodes carried in the top bits of the command word
    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_RESET   = 3'd1;
    localparam logic [2:0] OP_SET_LEN = 3'd2;
    localparam logic [2:0] OP_LOAD    = 3'd3;
    localparam logic [2:0] OP_DATA    = 3'd4;
    localparam logic [2:0] OP_START   = 3'd5;
    localparam logic [2:0] OP_READ    = 3'd6;
    localparam logic [2:0] OP_IDLE    = 3'd7;

    // Decoder FSM states; the encoding is visible in the status word
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Command word fields
    localparam int CMD_OPC_HI = 31;
    localparam int CMD_OPC_LO = 29;
    localparam int CMD_STROBE = 28;

    // Status word fields
    localparam int STAT_STATE_HI = 31;
    localparam int STAT_STATE_LO = 30;
    localparam int STAT_EOP      = 29;
    localparam int STAT_ACK      = 28;
    localparam int STAT_ERR      = 27;
    localparam int STAT_BD       = 26;

endpackage

// File: rtl/strobe_edge_det.sv
// Strobe toggle detector. Registers the previous strobe level and raises
// fire_o for one cycle per toggle. When the decoder is busy (block_i) the
// command word is parked in a one-deep holding register and replayed as soon
// as the block clears, so a toggle is never dropped.
module strobe_edge_det
    import cmd_pkg::*;
#(
    parameter int NB_GPIO = 32
) (
    input  logic               i_CLK,
    input  logic               i_reset,
    input  logic [NB_GPIO-1:0] gpio_data_i,
    input  logic               block_i,
    output logic               fire_o,
    output logic [NB_GPIO-1:0] cmd_o
);

    logic               strobe_q;
    logic               pend_q, pend_d;
    logic [NB_GPIO-1:0] cmd_q, cmd_d;
    logic               toggle;

    assign toggle = gpio_data_i[CMD_STROBE] ^ strobe_q;

    // Choose between a held command and a fresh toggle; park a toggle that
    // arrives while the decoder is blocked
    always_comb begin
        fire_o = 1'b0;
        cmd_o  = gpio_data_i;
        pend_d = pend_q;
        cmd_d  = cmd_q;
        if (pend_q) begin
            cmd_o  = cmd_q;
            fire_o = !block_i;
            if (!block_i) begin
                pend_d = toggle;
                cmd_d  = gpio_data_i;
            end
        end else begin
            fire_o = toggle && !block_i;
            if (toggle && block_i) begin
                pend_d = 1'b1;
                cmd_d  = gpio_data_i;
            end
        end
    end

    // Previous-strobe and holding registers; reset samples the live strobe so
    // no command fires when reset is released
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            strobe_q <= gpio_data_i[CMD_STROBE];
            pend_q   <= 1'b0;
            cmd_q    <= '0;
        end else begin
            strobe_q <= gpio_data_i[CMD_STROBE];
            pend_q   <= pend_d;
            cmd_q    <= cmd_d;
        end
    end

endmodule

// File: rtl/gpio_cmd_decoder.sv
// GPIO command decoder: turns strobed 32-bit command words from the
// processor into the load/SoP/valid/length levels for the convolution
// address FSM, presents pixel data, and reports state, ack, errors and
// read-back data on the GPIO input word.
//
// Handshake: the processor toggles bit 28 to issue one command and waits
// until the ack bit in o_gpio_data equals the strobe it sent; ack follows
// every completed command (for READ, only once the result is captured).
module gpio_cmd_decoder
    import cmd_pkg::*;
#(
    parameter int NB_GPIO      = 32,
    parameter int NB_IMAGE     = 10,
    parameter int NB_DATA      = 24,
    parameter int READ_LATENCY = 2
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic [NB_GPIO-1:0]  i_gpio_data,
    input  logic                i_EoP,
    input  logic                i_changeBlock,
    input  logic [NB_DATA-1:0]  i_result,
    output logic [NB_GPIO-1:0]  o_gpio_data,
    output logic                o_load,
    output logic                o_SoP,
    output logic                o_valid,
    output logic [NB_IMAGE-1:0] o_imgLength,
    output logic [NB_DATA-1:0]  o_data,
    output logic                o_fsm_reset
);

    localparam int CNT_W = $clog2(READ_LATENCY + 1);

    state_t              state_q;
    logic                load_q;
    logic                sop_q;
    logic                valid_q;
    logic                fsm_rst_q;
    logic                ack_q;
    logic                err_q;
    logic                bd_q;
    logic                rd_ack_q;
    logic [CNT_W-1:0]    rd_cnt_q;
    logic [NB_IMAGE-1:0] img_len_q;
    logic [NB_DATA-1:0]  data_q;
    logic [NB_DATA-1:0]  result_q;

    logic                block;
    logic                fire;
    logic [NB_GPIO-1:0]  cmd;
    logic [2:0]          opcode;
    logic                cmd_strobe;
    logic [NB_DATA-1:0]  payload;
    logic                cmd_legal;
    logic                unused_cmd_bits;
    logic [NB_GPIO-1:0]  status;

    // Hold commands while a valid pulse is out (keeps pulses apart), while a
    // READ capture is outstanding, and while RUN is ending on i_EoP
    assign block = valid_q || (rd_cnt_q != '0) || ((state_q == ST_RUN) && i_EoP);

    strobe_edge_det #(
        .NB_GPIO (NB_GPIO)
    ) u_strobe (
        .i_CLK       (i_CLK),
        .i_reset     (i_reset),
        .gpio_data_i (i_gpio_data),
        .block_i     (block),
        .fire_o      (fire),
        .cmd_o       (cmd)
    );

    assign opcode          = cmd[CMD_OPC_HI:CMD_OPC_LO];
    assign cmd_strobe      = cmd[CMD_STROBE];
    assign payload         = cmd[NB_DATA-1:0];
    assign unused_cmd_bits = ^cmd[CMD_STROBE-1:NB_DATA];

    // Classify the command against the current state
    always_comb begin
        cmd_legal = 1'b1;
        case (opcode)
            OP_SET_LEN, OP_START, OP_LOAD: cmd_legal = (state_q == ST_IDLE);
            OP_DATA:                       cmd_legal = (state_q == ST_LOAD);
            OP_READ:                       cmd_legal = i_EoP;
            default:                       cmd_legal = 1'b1;
        endcase
    end

    // Decoder FSM, command execution, read capture and status flags
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            load_q    <= 1'b0;
            sop_q     <= 1'b0;
            valid_q   <= 1'b0;
            fsm_rst_q <= 1'b0;
            // ack starts equal to the live strobe so the processor does not
            // see an outstanding command after reset
            ack_q     <= i_gpio_data[CMD_STROBE];
            err_q     <= 1'b0;
            bd_q      <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_cnt_q  <= '0;
            img_len_q <= '0;
            data_q    <= '0;
            result_q  <= '0;
        end else begin
            valid_q   <= 1'b0;
            fsm_rst_q <= 1'b0;

            case (state_q)
                ST_RUN: begin
                    if (i_EoP) begin
                        state_q <= ST_DONE;
                        sop_q   <= 1'b0;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: ;
            endcase

            if (rd_cnt_q != '0) begin
                rd_cnt_q <= rd_cnt_q - CNT_W'(1);
                if (rd_cnt_q == CNT_W'(1)) begin
                    result_q <= i_result;
                    ack_q    <= rd_ack_q;
                end
            end

            if (fire) begin
                if (!cmd_legal) begin
                    err_q <= 1'b1;
                    ack_q <= cmd_strobe;
                end else begin
                    if (opcode != OP_READ) begin
                        ack_q <= cmd_strobe;
                    end
                    case (opcode)
                        OP_NOP: ;
                        OP_RESET: begin
                            fsm_rst_q <= 1'b1;
                            state_q   <= ST_IDLE;
                            load_q    <= 1'b0;
                            sop_q     <= 1'b0;
                            img_len_q <= '0;
                            data_q    <= '0;
                            result_q  <= '0;
                            err_q     <= 1'b0;
                            bd_q      <= 1'b0;
                        end
                        OP_SET_LEN: img_len_q <= payload[NB_IMAGE-1:0];
                        OP_LOAD: begin
                            state_q <= ST_LOAD;
                            load_q  <= 1'b1;
                            bd_q    <= 1'b0;
                        end
                        OP_DATA: begin
                            data_q  <= payload;
                            valid_q <= 1'b1;
                        end
                        OP_START: begin
                            state_q <= ST_RUN;
                            sop_q   <= 1'b1;
                        end
                        OP_READ: begin
                            valid_q  <= 1'b1;
                            rd_cnt_q <= CNT_W'(READ_LATENCY);
                            rd_ack_q <= cmd_strobe;
                            bd_q     <= 1'b0;
                        end
                        OP_IDLE: begin
                            if (state_q == ST_LOAD) begin
                                state_q <= ST_IDLE;
                                load_q  <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            // A block-done arriving with a clearing command still registers
            if (i_changeBlock) begin
                bd_q <= 1'b1;
            end
        end
    end

    // Assemble the status word returned to the processor
    always_comb begin
        status                             = '0;
        status[STAT_STATE_HI:STAT_STATE_LO] = state_q;
        status[STAT_EOP]                   = i_EoP;
        status[STAT_ACK]                   = ack_q;
        status[STAT_ERR]                   = err_q;
        status[STAT_BD]                    = bd_q;
        status[NB_DATA-1:0]                = result_q;
    end

    assign o_gpio_data = status;
    assign o_load      = load_q;
    assign o_SoP       = sop_q;
    assign o_valid     = valid_q;
    assign o_imgLength = img_len_q;
    assign o_data      = data_q;
    assign o_fsm_reset = fsm_rst_q;

endmodule

// File: tb/tb_gpio_cmd_decoder.sv
// Testbench for gpio_cmd_decoder: feature tasks driving strobed commands,
// a negedge monitor checking every o_valid pulse against an expected queue.
module tb_gpio_cmd_decoder;

    localparam logic [2:0] C_NOP     = 3'd0;
    localparam logic [2:0] C_RESET   = 3'd1;
    localparam logic [2:0] C_SET_LEN = 3'd2;
    localparam logic [2:0] C_LOAD    = 3'd3;
    localparam logic [2:0] C_DATA    = 3'd4;
    localparam logic [2:0] C_START   = 3'd5;
    localparam logic [2:0] C_READ    = 3'd6;
    localparam logic [2:0] C_IDLE    = 3'd7;

    logic        i_CLK;
    logic        i_reset;
    logic [31:0] i_gpio_data;
    logic        i_EoP;
    logic        i_changeBlock;
    logic [23:0] i_result;
    logic [31:0] o_gpio_data;
    logic        o_load;
    logic        o_SoP;
    logic        o_valid;
    logic [9:0]  o_imgLength;
    logic [23:0] o_data;
    logic        o_fsm_reset;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];
    int          pulse_t[$];
    int          cyc = 0;
    logic        prev_valid = 1'b0;
    logic [23:0] mon_exp;
    logic        cur_strobe;
    logic [23:0] model_data;

    gpio_cmd_decoder dut (
        .i_CLK         (i_CLK),
        .i_reset       (i_reset),
        .i_gpio_data   (i_gpio_data),
        .i_EoP         (i_EoP),
        .i_changeBlock (i_changeBlock),
        .i_result      (i_result),
        .o_gpio_data   (o_gpio_data),
        .o_load        (o_load),
        .o_SoP         (o_SoP),
        .o_valid       (o_valid),
        .o_imgLength   (o_imgLength),
        .o_data        (o_data),
        .o_fsm_reset   (o_fsm_reset)
    );

    // Clock
    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    // Valid-pulse monitor: pulses must be single-cycle and match the queue
    always @(negedge i_CLK) begin
        cyc = cyc + 1;
        if (o_valid === 1'b1) begin
            pulse_t.push_back(cyc);
            n_cmp++;
            if (prev_valid === 1'b1) begin
                n_err++;
                $display("FAIL valid_width: o_valid high at cycle %0d and the cycle before, required single-cycle pulse", cyc);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL valid_unexpected: pulse at cycle %0d with o_data=%h, required no pulse", cyc, o_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (o_data !== mon_exp) begin
                    n_err++;
                    $display("FAIL valid_data: o_data=%h at pulse, required %h", o_data, mon_exp);
                end
            end
        end
        prev_valid = o_valid;
    end

    // Driver: toggle the strobe with a new command; returns at the negedge
    // of the cycle in which the toggle is presented
    task automatic drive_cmd(input logic [2:0] op, input logic [23:0] payload);
        @(posedge i_CLK);
        #1;
        cur_strobe  = ~cur_strobe;
        i_gpio_data = {op, cur_strobe, 4'b0000, payload};
        @(negedge i_CLK);
    endtask

    task automatic wait_ack(input string name);
        int k;
        k = 0;
        while (o_gpio_data[28] !== cur_strobe && k < 12) begin
            @(negedge i_CLK);
            k++;
        end
        n_cmp++;
        if (o_gpio_data[28] !== cur_strobe) begin
            n_err++;
            $display("FAIL %s_ack: ack=%b, required %b within 12 cycles", name, o_gpio_data[28], cur_strobe);
        end
    endtask

    task automatic test_reset();
        int n0;
        i_reset       = 1'b1;
        i_EoP         = 1'b0;
        i_changeBlock = 1'b0;
        i_result      = 24'h0;
        cur_strobe    = 1'b1;
        i_gpio_data   = {C_NOP, 1'b1, 4'b0000, 24'h0};
        model_data    = 24'h0;
        repeat (3) @(posedge i_CLK);
        #1 i_reset = 1'b0;
        n0 = pulse_t.size();
        repeat (5) @(negedge i_CLK);
        n_cmp++;
        if (o_gpio_data !== 32'h1000_0000) begin
            n_err++;
            $display("FAIL reset_status: o_gpio_data=%h, required %h", o_gpio_data, 32'h1000_0000);
        end
        n_cmp++;
        if ({o_load, o_SoP, o_valid, o_fsm_reset} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: load/sop/valid/fsm_reset=%b, required 0000", {o_load, o_SoP, o_valid, o_fsm_reset});
        end
        n_cmp++;
        if (o_imgLength !== 10'd0 || o_data !== 24'd0) begin
            n_err++;
            $display("FAIL reset_len_data: len=%h data=%h, required 0 and 0", o_imgLength, o_data);
        end
        n_cmp++;
        if (pulse_t.size() != n0) begin
            n_err++;
            $display("FAIL reset_no_valid: %0d pulses after reset, required 0", pulse_t.size() - n0);
        end
    endtask

    task automatic test_load_data();
        logic [23:0] pay [4];
        int n0;
        pay[0] = 24'h010203;
        pay[1] = 24'h040506;
        pay[2] = 24'h070809;
        pay[3] = 24'h0A0B0C;
        drive_cmd(C_SET_LEN, 24'hABC3FF);
        wait_ack("set_len");
        n_cmp++;
        if (o_imgLength !== 10'h3FF) begin
            n_err++;
            $display("FAIL set_len: o_imgLength=%h, required %h", o_imgLength, 10'h3FF);
        end
        drive_cmd(C_LOAD, 24'h0);
        wait_ack("load");
        n_cmp++;
        if (o_load !== 1'b1 || o_gpio_data[31:30] !== 2'd1) begin
            n_err++;
            $display("FAIL load_state: o_load=%b state=%0d, required 1 and 1", o_load, o_gpio_data[31:30]);
        end
        n0 = pulse_t.size();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pay[i]);
            model_data = pay[i];
            drive_cmd(C_DATA, pay[i]);
            wait_ack("data");
            repeat (2) @(negedge i_CLK);
        end
        n_cmp++;
        if (pulse_t.size() - n0 != 4 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL data_pulses: %0d pulses (%0d unmatched), required 4 (0)", pulse_t.size() - n0, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = pulse_t.size();
        exp_q.push_back(24'h111111);
        exp_q.push_back(24'h222222);
        drive_cmd(C_DATA, 24'h111111);
        drive_cmd(C_DATA, 24'h222222);
        model_data = 24'h222222;
        repeat (6) @(negedge i_CLK);
        n_cmp++;
        if (pulse_t.size() - n0 != 2) begin
            n_err++;
            $display("FAIL b2b_count: %0d pulses, required 2", pulse_t.size() - n0);
        end else begin
            n_cmp++;
            if (pulse_t[n0+1] - pulse_t[n0] != 2) begin
                n_err++;
                $display("FAIL b2b_gap: pulses %0d cycles apart, required 2", pulse_t[n0+1] - pulse_t[n0]);
            end
        end
        wait_ack("b2b");
        drive_cmd(C_IDLE, 24'h0);
        wait_ack("idle");
        n_cmp++;
        if (o_load !== 1'b0 || o_gpio_data[31:30] !== 2'd0) begin
            n_err++;
            $display("FAIL idle_state: o_load=%b state=%0d, required 0 and 0", o_load, o_gpio_data[31:30]);
        end
    endtask

    task automatic test_random_data();
        logic [23:0] p;
        drive_cmd(C_LOAD, 24'h0);
        wait_ack("rnd_load");
        for (int i = 0; i < 6; i++) begin
            p = 24'($urandom_range(0, 24'hFFFFFF));
            exp_q.push_back(p);
            model_data = p;
            drive_cmd(C_DATA, p);
            repeat ($urandom_range(1, 3)) @(negedge i_CLK);
        end
        repeat (8) @(negedge i_CLK);
        n_cmp++;
        if (exp_q.size() != 0 || o_data !== model_data) begin
            n_err++;
            $display("FAIL rnd_data: %0d unmatched, o_data=%h, required 0 and %h", exp_q.size(), o_data, model_data);
        end
        wait_ack("rnd");
        drive_cmd(C_IDLE, 24'h0);
        wait_ack("rnd_idle");
    endtask

    task automatic test_start_run();
        int sop_cnt;
        i_EoP = 1'b0;
        drive_cmd(C_START, 24'h0);
        sop_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_CLK);
            if (o_SoP === 1'b1 && o_gpio_data[31:30] === 2'd2) sop_cnt++;
        end
        n_cmp++;
        if (o_gpio_data[28] !== cur_strobe) begin
            n_err++;
            $display("FAIL start_ack: ack=%b, required %b", o_gpio_data[28], cur_strobe);
        end
        i_EoP = 1'b1;
        @(negedge i_CLK);
        n_cmp++;
        if (o_SoP !== 1'b0 || o_gpio_data[31:29] !== 3'b111) begin
            n_err++;
            $display("FAIL run_done: o_SoP=%b state/eop=%b, required 0 and 111", o_SoP, o_gpio_data[31:29]);
        end
        @(negedge i_CLK);
        n_cmp++;
        if (o_SoP !== 1'b0 || o_gpio_data[31:30] !== 2'd0) begin
            n_err++;
            $display("FAIL done_idle: o_SoP=%b state=%0d, required 0 and 0", o_SoP, o_gpio_data[31:30]);
        end
        n_cmp++;
        if (sop_cnt != 20) begin
            n_err++;
            $display("FAIL sop_cycles: o_SoP high in RUN for %0d cycles, required 20", sop_cnt);
        end
    endtask

    task automatic test_read_back();
        logic old_ack;
        @(negedge i_CLK);
        i_changeBlock = 1'b1;
        @(negedge i_CLK);
        i_changeBlock = 1'b0;
        n_cmp++;
        if (o_gpio_data[26] !== 1'b1) begin
            n_err++;
            $display("FAIL blockdone_set: bit26=%b, required 1", o_gpio_data[26]);
        end
        i_result = 24'hABCDEF;
        old_ack  = cur_strobe;
        exp_q.push_back(model_data);
        drive_cmd(C_READ, 24'h0);
        @(negedge i_CLK);
        n_cmp++;
        if (o_valid !== 1'b1 || o_gpio_data[26] !== 1'b0) begin
            n_err++;
            $display("FAIL read_pulse: o_valid=%b bit26=%b, required 1 and 0", o_valid, o_gpio_data[26]);
        end
        @(negedge i_CLK);
        n_cmp++;
        if (o_gpio_data[23:0] !== 24'h0 || o_gpio_data[28] !== old_ack) begin
            n_err++;
            $display("FAIL read_early: result=%h ack=%b one cycle after pulse, required 000000 and %b", o_gpio_data[23:0], o_gpio_data[28], old_ack);
        end
        @(negedge i_CLK);
        n_cmp++;
        if (o_gpio_data[23:0] !== 24'hABCDEF || o_gpio_data[28] !== cur_strobe) begin
            n_err++;
            $display("FAIL read_capture: result=%h ack=%b two cycles after pulse, required abcdef and %b", o_gpio_data[23:0], o_gpio_data[28], cur_strobe);
        end
    endtask

    task automatic test_illegal_and_reset();
        int n0;
        n0 = pulse_t.size();
        drive_cmd(C_DATA, 24'h555555);
        wait_ack("illegal_data");
        n_cmp++;
        if (o_gpio_data[27] !== 1'b1 || o_gpio_data[31:30] !== 2'd0 || o_data !== model_data) begin
            n_err++;
            $display("FAIL illegal_data: err=%b state=%0d o_data=%h, required 1, 0, %h", o_gpio_data[27], o_gpio_data[31:30], o_data, model_data);
        end
        i_EoP = 1'b0;
        drive_cmd(C_READ, 24'h0);
        wait_ack("illegal_read");
        repeat (3) @(negedge i_CLK);
        n_cmp++;
        if (pulse_t.size() != n0 || o_gpio_data[27] !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_no_pulse: %0d pulses err=%b, required 0 and 1", pulse_t.size() - n0, o_gpio_data[27]);
        end
        drive_cmd(C_RESET, 24'h0);
        @(negedge i_CLK);
        n_cmp++;
        if (o_fsm_reset !== 1'b1 || o_gpio_data !== {3'b000, cur_strobe, 28'h0}) begin
            n_err++;
            $display("FAIL reset_op: fsm_reset=%b status=%h, required 1 and %h", o_fsm_reset, o_gpio_data, {3'b000, cur_strobe, 28'h0});
        end
        n_cmp++;
        if (o_imgLength !== 10'd0 || o_data !== 24'd0) begin
            n_err++;
            $display("FAIL reset_op_clear: len=%h data=%h, required 0 and 0", o_imgLength, o_data);
        end
        model_data = 24'h0;
        @(negedge i_CLK);
        n_cmp++;
        if (o_fsm_reset !== 1'b0) begin
            n_err++;
            $display("FAIL reset_op_width: o_fsm_reset=%b second cycle, required 0", o_fsm_reset);
        end
    endtask

    task automatic test_mid_reset();
        drive_cmd(C_START, 24'h0);
        repeat (3) @(negedge i_CLK);
        i_reset = 1'b1;
        @(negedge i_CLK);
        i_reset = 1'b0;
        @(negedge i_CLK);
        n_cmp++;
        if (o_SoP !== 1'b0 || o_gpio_data[31:30] !== 2'd0) begin
            n_err++;
            $display("FAIL midrst_run: o_SoP=%b state=%0d, required 0 and 0", o_SoP, o_gpio_data[31:30]);
        end
        i_EoP = 1'b1;
        exp_q.push_back(model_data);
        drive_cmd(C_READ, 24'h0);
        @(negedge i_CLK);
        i_reset = 1'b1;
        @(negedge i_CLK);
        i_reset = 1'b0;
        repeat (4) @(negedge i_CLK);
        n_cmp++;
        if (o_gpio_data[23:0] !== 24'h0 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_read: result=%h valid=%b after reset, required 000000 and 0", o_gpio_data[23:0], o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_load_data();
        test_back_to_back();
        test_random_data();
        test_start_run();
        test_read_back();
        test_illegal_and_reset();
        test_mid_reset();
        repeat (3) @(negedge i_CLK);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL final_queue: %0d expected pulses never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
